// File: rtl/gberet_vid_pkg.sv
// ----------------------------------------------------------------------------
// gberet_vid_pkg
// Shared definitions for the video-board CPU responder: CPU address map
// bases/limits, control-register bit positions, and the address decoder that
// turns a CPU address into a one-hot region vector.
// ----------------------------------------------------------------------------
package gberet_vid_pkg;

   // Region bases; each region ends one below the next base.
   localparam logic [15:0] COL_BASE   = 16'hC000;  // colour RAM, 2 KiB
   localparam logic [15:0] TILE_BASE  = 16'hC800;  // tile RAM, 2 KiB
   localparam logic [15:0] SPR0_BASE  = 16'hD000;  // sprite buffer 0
   localparam logic [15:0] SPR1_BASE  = 16'hD100;  // sprite buffer 1
   localparam logic [15:0] WORK_BASE  = 16'hD200;  // work RAM, 3.5 KiB
   localparam logic [15:0] SCRLO_BASE = 16'hE000;  // scroll low bytes
   localparam logic [15:0] SCRHI_BASE = 16'hE020;  // scroll high bits
   localparam logic [15:0] VID_LIMIT  = 16'hE03F;  // last readable address
   localparam logic [15:0] SPRBK_ADDR = 16'hE043;  // sprite bank, write only
   localparam logic [15:0] CTRL_ADDR  = 16'hE044;  // control, write only

   localparam int FLIP_BIT  = 3;
   localparam int SPRBK_BIT = 3;
   localparam int WORK_AW   = 12;   // work RAM indexed by CPUAD[11:0]
   localparam int SCR_ROWS  = 32;

   // One-hot decode of the CPU address.
   typedef struct packed {
      logic col;
      logic tile;
      logic spr0;
      logic spr1;
      logic work;
      logic scr_lo;
      logic scr_hi;
      logic sprbk;
      logic ctrl;
   } region_t;

   // Registered read-source select for the CPU read mux.
   typedef struct packed {
      logic col;
      logic tile;
      logic spr0;
      logic spr1;
      logic work;
      logic scr;
   } rd_sel_t;

   function automatic region_t decode_region(input logic [15:0] a);
      region_t r;
      r        = '0;
      r.col    = (a >= COL_BASE)   && (a < TILE_BASE);
      r.tile   = (a >= TILE_BASE)  && (a < SPR0_BASE);
      r.spr0   = (a >= SPR0_BASE)  && (a < SPR1_BASE);
      r.spr1   = (a >= SPR1_BASE)  && (a < WORK_BASE);
      r.work   = (a >= WORK_BASE)  && (a < SCRLO_BASE);
      r.scr_lo = (a >= SCRLO_BASE) && (a < SCRHI_BASE);
      r.scr_hi = (a >= SCRHI_BASE) && (a <= VID_LIMIT);
      r.sprbk  = (a == SPRBK_ADDR);
      r.ctrl   = (a == CTRL_ADDR);
      return r;
   endfunction

endpackage

// File: rtl/video_cpu_if_if.sv
// ----------------------------------------------------------------------------
// cpu_bus_if
// Main-board Z80 bus as seen by the video board.
//   CPUMX  memory request      CPUAD  address
//   CPUWR  write strobe        CPUWD  write data
//   VIDDV  read data valid     VIDRD  read data
// master = CPU side, slave = video responder.
// ----------------------------------------------------------------------------
interface cpu_bus_if;
   logic        CPUMX;
   logic [15:0] CPUAD;
   logic        CPUWR;
   logic [7:0]  CPUWD;
   logic        VIDDV;
   logic [7:0]  VIDRD;

   modport master (output CPUMX, CPUAD, CPUWR, CPUWD, input VIDDV, VIDRD);
   modport slave  (input CPUMX, CPUAD, CPUWR, CPUWD, output VIDDV, VIDRD);
endinterface

// File: rtl/video_cpu_if_dpram_rf.sv
// ----------------------------------------------------------------------------
// dpram_rf
// Dual-port RAM, independent clocks per port.
//   Port A (clk_a): read/write, write-first, registered dout_a.
//   Port B (clk_b): read only, registered dout_b with sync reset rst_b;
//                   a same-edge write on port A is not seen (old data).
// ----------------------------------------------------------------------------
module dpram_rf #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   output logic [DW-1:0] dout_a,
   input  logic          clk_b,
   input  logic          rst_b,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] dout_b
);

   localparam int DEPTH = 1 << AW;

   // NOTE: the array has no reset; clearing it would prevent RAM inference.
   logic [DW-1:0] mem [DEPTH];

   // NOTE: non-blocking writes, so port B on the same edge reads the old word.
   always_ff @(posedge clk_a) begin
      if (we_a) begin
         mem[addr_a] <= din_a;
         dout_a      <= din_a;
      end else begin
         dout_a      <= mem[addr_a];
      end
   end

   always_ff @(posedge clk_b) begin
      if (rst_b) dout_b <= '0;
      else       dout_b <= mem[addr_b];
   end

endmodule

// File: rtl/video_cpu_if.sv
// ----------------------------------------------------------------------------
// video_cpu_if
// CPU-bus responder for the video board: decodes the Z80 bus for video RAMs
// and registers, performs writes, returns registered read data, and serves
// the tile/sprite engines through the RAMs' second ports.
//   CLK, RESET      clock, synchronous active-high reset
//   bus (slave)     CPUMX/CPUAD/CPUWR/CPUWD in, VIDDV/VIDRD out
//   BGAD -> BGCL/BGCH   colour / tile RAM bytes, one cycle latency
//   SPAD -> SPDT        display sprite buffer byte, one cycle latency
//   SCRW -> SCRX        9-bit row scroll, one cycle latency
//   FLIP                flip-screen bit from the control register
// ----------------------------------------------------------------------------
module video_cpu_if
   import gberet_vid_pkg::*;
#(
   parameter int SCRN_AW = 11,
   parameter int SPR_AW  = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   cpu_bus_if.slave           bus,
   input  logic [SCRN_AW-1:0] BGAD,
   output logic [7:0]         BGCL,
   output logic [7:0]         BGCH,
   input  logic [SPR_AW-1:0]  SPAD,
   output logic [7:0]         SPDT,
   input  logic [4:0]         SCRW,
   output logic [8:0]         SCRX,
   output logic               FLIP
);

   region_t       hit;
   rd_sel_t       rd_sel_q;
   logic          wr_en;
   logic [4:0]    scr_idx;

   logic [7:0]    scr_lo_q [SCR_ROWS];
   logic [SCR_ROWS-1:0] scr_hi_q;
   logic [7:0]    scr_rd_q;
   logic [8:0]    scrx_q;
   logic          sprbk_q;
   logic          flip_q;

   logic [7:0]    col_a, tile_a, spr0_a, spr1_a, work_a;
   logic [7:0]    spr0_b, spr1_b;
   logic [7:0]    work_dout_b_unused;

   always_comb begin
      // NOTE: default assigned first so every path drives hit (no latch).
      hit = '0;
      if (bus.CPUMX) hit = decode_region(bus.CPUAD);
   end

   // RESET suppresses any write presented on the same edge.
   assign wr_en   = bus.CPUWR & ~RESET;
   assign scr_idx = bus.CPUAD[4:0];

   // Only C000-E03F is readable; the two write-only registers stay invalid.
   assign bus.VIDDV = hit.col | hit.tile | hit.spr0 | hit.spr1 | hit.work |
                      hit.scr_lo | hit.scr_hi;

   // ---------------------------------------------------------------- RAMs
   dpram_rf #(.AW(SCRN_AW), .DW(8)) u_col (
      .clk_a (CLK), .we_a (hit.col & wr_en), .addr_a (bus.CPUAD[SCRN_AW-1:0]),
      .din_a (bus.CPUWD), .dout_a (col_a),
      .clk_b (CLK), .rst_b (RESET), .addr_b (BGAD), .dout_b (BGCL)
   );

   dpram_rf #(.AW(SCRN_AW), .DW(8)) u_tile (
      .clk_a (CLK), .we_a (hit.tile & wr_en), .addr_a (bus.CPUAD[SCRN_AW-1:0]),
      .din_a (bus.CPUWD), .dout_a (tile_a),
      .clk_b (CLK), .rst_b (RESET), .addr_b (BGAD), .dout_b (BGCH)
   );

   // CPU addresses hit the physical buffers directly; sprbk only steers SPDT.
   dpram_rf #(.AW(SPR_AW), .DW(8)) u_spr0 (
      .clk_a (CLK), .we_a (hit.spr0 & wr_en), .addr_a (bus.CPUAD[SPR_AW-1:0]),
      .din_a (bus.CPUWD), .dout_a (spr0_a),
      .clk_b (CLK), .rst_b (RESET), .addr_b (SPAD), .dout_b (spr0_b)
   );

   dpram_rf #(.AW(SPR_AW), .DW(8)) u_spr1 (
      .clk_a (CLK), .we_a (hit.spr1 & wr_en), .addr_a (bus.CPUAD[SPR_AW-1:0]),
      .din_a (bus.CPUWD), .dout_a (spr1_a),
      .clk_b (CLK), .rst_b (RESET), .addr_b (SPAD), .dout_b (spr1_b)
   );

   // Work RAM uses CPUAD[11:0] directly; offsets 000-1FF are never decoded.
   dpram_rf #(.AW(WORK_AW), .DW(8)) u_work (
      .clk_a (CLK), .we_a (hit.work & wr_en), .addr_a (bus.CPUAD[WORK_AW-1:0]),
      .din_a (bus.CPUWD), .dout_a (work_a),
      .clk_b (CLK), .rst_b (RESET), .addr_b ({WORK_AW{1'b0}}),
      .dout_b (work_dout_b_unused)
   );

   // --------------------------------------------- registers and read select
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < SCR_ROWS; i++) scr_lo_q[i] <= '0;
         scr_hi_q <= '0;
         scr_rd_q <= '0;
         scrx_q   <= '0;
         sprbk_q  <= 1'b0;
         flip_q   <= 1'b0;
         rd_sel_q <= '0;
      end else begin
         if (hit.scr_lo && wr_en) scr_lo_q[scr_idx] <= bus.CPUWD;
         if (hit.scr_hi && wr_en) scr_hi_q[scr_idx] <= bus.CPUWD[0];
         if (hit.sprbk  && wr_en) sprbk_q <= bus.CPUWD[SPRBK_BIT];
         if (hit.ctrl   && wr_en) flip_q  <= bus.CPUWD[FLIP_BIT];

         scrx_q   <= {scr_hi_q[SCRW], scr_lo_q[SCRW]};
         scr_rd_q <= hit.scr_lo ? scr_lo_q[scr_idx] : {7'b0, scr_hi_q[scr_idx]};

         rd_sel_q <= '{col:  hit.col,  tile: hit.tile, spr0: hit.spr0,
                       spr1: hit.spr1, work: hit.work,
                       scr:  hit.scr_lo | hit.scr_hi};
      end
   end

   // One-hot select gates exactly one registered source onto VIDRD.
   assign bus.VIDRD = ({8{rd_sel_q.col}}  & col_a)  |
                      ({8{rd_sel_q.tile}} & tile_a) |
                      ({8{rd_sel_q.spr0}} & spr0_a) |
                      ({8{rd_sel_q.spr1}} & spr1_a) |
                      ({8{rd_sel_q.work}} & work_a) |
                      ({8{rd_sel_q.scr}}  & scr_rd_q);

   // Display reads the buffer the CPU is not filling.
   assign SPDT = sprbk_q ? spr0_b : spr1_b;
   assign SCRX = scrx_q;
   assign FLIP = flip_q;

endmodule
